spi_oled_ctrl: RTL and testbench
================================

SPI_OLED_CTRL -- requirements
Module: spi_oled_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per spi_clk period; even, >=2.
REQ-002 SHALL have parameter INIT_LEN, default 8: number of power-up command bytes taken from the package init table; 0..16.
REQ-003 SHALL have parameter RST_CYCLES, default 16: oled_rst_n low-pulse length in clk cycles; >=1.
REQ-004 clk  input  1  system clock; the only clock.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  host byte available.
REQ-007 in_ready  output  1  controller accepts a host byte this cycle.
REQ-008 in_byte  input  8  host byte.
REQ-009 in_dc  input  1  host byte type: 0 = command, 1 = display data.
REQ-010 spi_clk  output  1  SPI clock, mode 0 (idles low).
REQ-011 spi_mosi  output  1  serial data, MSB first.
REQ-012 spi_cs_n  output  1  chip select, active low.
REQ-013 spi_dc  output  1  data/command line for the current byte.
REQ-014 init_done  output  1  high once the init table has been sent; stays high until reset.
REQ-015 busy  output  1  high whenever the controller is not in IDLE.
REQ-016 oled_rst_n  output  1  panel reset; present only with SPI_OLED_RESET_PULSE_EN.

Function
REQ-017 FSM states SHALL be RST_PULSE, INIT_LOAD, SHIFT, GAP, IDLE.
REQ-018 After reset the FSM SHALL enter RST_PULSE (macro defined) or INIT_LOAD (macro undefined).
- With INIT_LEN=0 it SHALL go directly to IDLE and assert init_done on the next edge.
REQ-019 INIT_LOAD SHALL load table entry init_idx with spi_dc=0 and enter SHIFT in one cycle.
REQ-020 SHIFT SHALL drive spi_cs_n=0 and 8 spi_clk periods.
- Each period is CLK_DIV/2 cycles low, then CLK_DIV/2 cycles high.
- spi_mosi changes only while spi_clk is low and holds bit 7..0 across each rising edge.
- A byte SHALL take exactly 8*CLK_DIV cycles.
REQ-021 GAP SHALL hold spi_cs_n=1 and spi_clk=0 for exactly CLK_DIV/2 cycles.
- GAP then goes to INIT_LOAD if init_idx < INIT_LEN, otherwise to IDLE.
- init_done SHALL rise on the cycle IDLE is first entered.
REQ-022 in_ready SHALL equal (state==IDLE && init_done).
- in_valid while in_ready=0 SHALL be ignored; no byte is lost, because the host holds in_valid.
REQ-023 A transfer SHALL occur on a rising edge with in_valid&&in_ready.
- in_byte and in_dc are captured, spi_dc takes in_dc, and the FSM enters SHIFT with in_ready low from the next cycle.
REQ-024 spi_dc SHALL remain stable from SHIFT entry through the end of the following GAP.
REQ-025 init_idx SHALL be a 5-bit counter incremented at each INIT_LOAD.
- It SHALL never wrap; INIT_LEN=16 sends entries 0..15.
REQ-026 The SPI bit counter (3 bits) SHALL wrap from 0 to 7 only on leaving SHIFT.
- The divider counter SHALL be sized to clog2(CLK_DIV).

Reset
REQ-027 On rst, all outputs SHALL take their reset values on the same edge, including mid-byte; any partial byte is abandoned.
- spi_clk=0, spi_mosi=0, spi_cs_n=1, spi_dc=0, in_ready=0, init_done=0, busy=1, oled_rst_n=0.
REQ-028 After rst deasserts, the full init sequence SHALL be re-sent.

Configuration
REQ-029 With SPI_OLED_RESET_PULSE_EN defined:
- RST_PULSE holds oled_rst_n=0 for RST_CYCLES cycles, then sets oled_rst_n=1 and enters INIT_LOAD.
- oled_rst_n stays 1 until rst.
REQ-030 Without SPI_OLED_RESET_PULSE_EN:
- The oled_rst_n port and the RST_PULSE state SHALL be absent.
- Reset exits to INIT_LOAD.

Structure
REQ-031 Package spi_oled_pkg SHALL hold:
- The state enum.
- The 16x8 init table constant, with entries 0..7 = 8D,14,81,CF,D9,F1,A4,AF and the rest 00.
- Command-byte localparams.
REQ-032 Sub-module spi_byte_shifter SHALL own the divider, bit counter and mosi/spi_clk generation, with start/done handshake; the FSM stays in spi_oled_ctrl.

Verification
REQ-033 Defaults, macro undefined, release rst:
- cs_n falls 1 cycle later; 8 bytes 8D..AF appear on mosi sampled at spi_clk rising edges.
- Each byte spans 32 cycles with cs_n low, and 2 cycles of cs_n high between bytes.
- init_done rises 8*(1+32+2) = 280 cycles after reset release.
REQ-034 After init, in_valid=1, in_byte=A5, in_dc=1:
- Accepted on the first edge, in_ready low next cycle.
- Bits 1,0,1,0,0,1,0,1 sampled, spi_dc=1 throughout.
- in_ready high again 35 cycles after acceptance.
REQ-035 in_valid held high during init: no acceptance before init_done; the first host byte starts only after IDLE.
REQ-036 rst asserted 10 cycles into byte 3 of init:
- Next edge gives cs_n=1, spi_clk=0, init_done=0.
- After release the sequence restarts at 8D.
REQ-037 SPI_OLED_RESET_PULSE_EN defined, RST_CYCLES=16: oled_rst_n low for exactly 16 cycles after reset release, then the first init byte begins on the next cycle.
REQ-038 CLK_DIV=2, INIT_LEN=0: init_done high one cycle after reset; byte 3C sent in 16 cycles with spi_clk toggling every cycle.

Source files
------------

// File: rtl/spi_oled_pkg.sv
// spi_oled_pkg: shared types and constants for the SPI OLED controller.
//   state_t     - controller FSM state encoding
//   CMD_*       - panel command bytes used by the power-up sequence
//   INIT_TABLE  - 16-entry power-up command table (unused entries are 00)
//   init_byte() - table lookup helper
// Optional feature macro: SPI_OLED_RESET_PULSE_EN adds the RST_PULSE state.
package spi_oled_pkg;

  localparam int unsigned INIT_DEPTH = 16;

  typedef enum logic [2:0] {
`ifdef SPI_OLED_RESET_PULSE_EN
    RST_PULSE,
`endif
    INIT_LOAD,
    SHIFT,
    GAP,
    IDLE
  } state_t;

  localparam logic [7:0] CMD_CHARGE_PUMP    = 8'h8D;
  localparam logic [7:0] CMD_CHARGE_PUMP_ON = 8'h14;
  localparam logic [7:0] CMD_SET_CONTRAST   = 8'h81;
  localparam logic [7:0] CMD_CONTRAST_VAL   = 8'hCF;
  localparam logic [7:0] CMD_SET_PRECHARGE  = 8'hD9;
  localparam logic [7:0] CMD_PRECHARGE_VAL  = 8'hF1;
  localparam logic [7:0] CMD_DISPLAY_RESUME = 8'hA4;
  localparam logic [7:0] CMD_DISPLAY_ON     = 8'hAF;

  // Entry 0 is the leftmost element.
  localparam logic [0:INIT_DEPTH-1][7:0] INIT_TABLE = {
    CMD_CHARGE_PUMP, CMD_CHARGE_PUMP_ON, CMD_SET_CONTRAST, CMD_CONTRAST_VAL,
    CMD_SET_PRECHARGE, CMD_PRECHARGE_VAL, CMD_DISPLAY_RESUME, CMD_DISPLAY_ON,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] init_byte(input logic [3:0] idx);
    return INIT_TABLE[idx];
  endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// spi_byte_shifter: serialises one byte as SPI mode 0, MSB first.
//   clk, rst  - system clock, synchronous active-high reset
//   start     - load data and begin a byte (ignored fields while idle are harmless)
//   data      - byte to send, sampled when start is high
//   done_c    - combinational pulse in the last cycle of the byte
//   spi_clk   - serial clock, idles low
//   spi_mosi  - serial data, changes only while spi_clk is low
module spi_byte_shifter #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       done_c,
  output logic       spi_clk,
  output logic       spi_mosi
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2 - 1);

  logic             active;
  logic [DIV_W-1:0] div;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;

  // Counts down 7..0; the decrement after bit 0 wraps it back to 7 as the byte ends.
  assign done_c = active && (div == DIV_LAST) && (bit_cnt == 3'd0);

  // Divider, bit counter and serial output generation.
  always_ff @(posedge clk) begin
    if (rst) begin
      active   <= 1'b0;
      div      <= '0;
      bit_cnt  <= 3'd7;
      shreg    <= 8'h00;
      spi_clk  <= 1'b0;
      spi_mosi <= 1'b0;
    end else if (start) begin
      active   <= 1'b1;
      div      <= '0;
      bit_cnt  <= 3'd7;
      shreg    <= data;
      spi_clk  <= 1'b0;
      spi_mosi <= data[7];
    end else if (active) begin
      if (div == DIV_LAST) begin
        // Falling edge: advance to the next bit while the clock goes low.
        div      <= '0;
        spi_clk  <= 1'b0;
        bit_cnt  <= bit_cnt - 3'd1;
        shreg    <= {shreg[6:0], 1'b0};
        spi_mosi <= (bit_cnt == 3'd0) ? 1'b0 : shreg[6];
        if (bit_cnt == 3'd0) begin
          active <= 1'b0;
        end
      end else begin
        div <= div + DIV_W'(1);
        if (div == DIV_HALF) begin
          spi_clk <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/spi_oled_ctrl.sv
// spi_oled_ctrl: SPI OLED panel controller. Sends a power-up command table,
// then forwards host bytes (command or display data) over SPI mode 0.
//   clk, rst              - system clock, synchronous active-high reset
//   in_valid/in_ready     - host byte handshake; in_byte/in_dc are the payload
//   spi_clk/spi_mosi      - serial clock and data (from spi_byte_shifter)
//   spi_cs_n/spi_dc       - chip select and data/command line
//   init_done             - power-up table has been sent
//   busy                  - controller not in IDLE
//   oled_rst_n            - panel reset pulse (only with SPI_OLED_RESET_PULSE_EN)
// Optional feature macro: SPI_OLED_RESET_PULSE_EN.
module spi_oled_ctrl
  import spi_oled_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned INIT_LEN   = 8,
  parameter int unsigned RST_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_byte,
  input  logic       in_dc,
  output logic       spi_clk,
  output logic       spi_mosi,
  output logic       spi_cs_n,
  output logic       spi_dc,
  output logic       init_done,
  output logic       busy
`ifdef SPI_OLED_RESET_PULSE_EN
  ,
  output logic       oled_rst_n
`endif
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] GAP_LAST = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [4:0] INIT_END = 5'(INIT_LEN);

  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0 || INIT_LEN > INIT_DEPTH || RST_CYCLES < 1) begin : g_bad_param
    $error("spi_oled_ctrl: illegal parameter combination");
  end

`ifdef SPI_OLED_RESET_PULSE_EN
  localparam int unsigned RC_W = $clog2(RST_CYCLES + 1);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);
  localparam state_t RESET_STATE = RST_PULSE;
  logic [RC_W-1:0] rcnt_q, rcnt_d;
  logic            orst_d;
`else
  localparam state_t RESET_STATE = INIT_LOAD;
`endif

  state_t           state_q, state_d;
  logic [4:0]       idx_q, idx_d;
  logic [DIV_W-1:0] gap_q, gap_d;
  logic             dc_d, init_done_d, in_ready_d, cs_n_d, busy_d;
  logic             start_c, done_c;
  logic [7:0]       load_byte;

  spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .start    (start_c),
    .data     (load_byte),
    .done_c   (done_c),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi)
  );

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RESET_STATE;
      idx_q     <= 5'd0;
      gap_q     <= '0;
      spi_dc    <= 1'b0;
      init_done <= 1'b0;
      in_ready  <= 1'b0;
      spi_cs_n  <= 1'b1;
      busy      <= 1'b1;
`ifdef SPI_OLED_RESET_PULSE_EN
      rcnt_q     <= '0;
      oled_rst_n <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      spi_dc    <= dc_d;
      init_done <= init_done_d;
      in_ready  <= in_ready_d;
      spi_cs_n  <= cs_n_d;
      busy      <= busy_d;
`ifdef SPI_OLED_RESET_PULSE_EN
      rcnt_q     <= rcnt_d;
      oled_rst_n <= orst_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    dc_d        = spi_dc;
    init_done_d = init_done;
    start_c     = 1'b0;
    load_byte   = 8'h00;
`ifdef SPI_OLED_RESET_PULSE_EN
    rcnt_d      = rcnt_q;
    orst_d      = oled_rst_n;
`endif
    case (state_q)
`ifdef SPI_OLED_RESET_PULSE_EN
      RST_PULSE: begin
        rcnt_d = rcnt_q + RC_W'(1);
        if (rcnt_q == RC_LAST) begin
          orst_d  = 1'b1;
          state_d = INIT_LOAD;
        end
      end
`endif
      INIT_LOAD: begin
        // An empty table (INIT_LEN=0) falls straight through to IDLE.
        if (idx_q < INIT_END) begin
          start_c   = 1'b1;
          load_byte = init_byte(idx_q[3:0]);
          dc_d      = 1'b0;
          idx_d     = idx_q + 5'd1;
          state_d   = SHIFT;
        end else begin
          init_done_d = 1'b1;
          state_d     = IDLE;
        end
      end
      SHIFT: begin
        if (done_c) begin
          gap_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        gap_d = gap_q + DIV_W'(1);
        if (gap_q == GAP_LAST) begin
          gap_d = '0;
          if (idx_q < INIT_END) begin
            state_d = INIT_LOAD;
          end else begin
            init_done_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      IDLE: begin
        if (in_valid && in_ready) begin
          start_c   = 1'b1;
          load_byte = in_byte;
          dc_d      = in_dc;
          state_d   = SHIFT;
        end
      end
      default: state_d = RESET_STATE;
    endcase
    in_ready_d = (state_d == IDLE) && init_done_d;
    cs_n_d     = (state_d != SHIFT);
    busy_d     = (state_d != IDLE);
  end

endmodule

// File: tb/tb_spi_oled_ctrl.sv
// tb_spi_oled_ctrl: directed bench for spi_oled_ctrl (default build, macro undefined).
// dut uses default parameters; dut_b uses CLK_DIV=2, INIT_LEN=0.
module tb_spi_oled_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, in_dc, in_ready;
  logic [7:0] in_byte;
  logic       spi_clk, spi_mosi, spi_cs_n, spi_dc, init_done, busy;
  logic       rst_b, in_valid_b, in_dc_b, in_ready_b;
  logic [7:0] in_byte_b;
  logic       spi_clk_b, spi_mosi_b, spi_cs_n_b, spi_dc_b, init_done_b, busy_b;
`ifdef SPI_OLED_RESET_PULSE_EN
  logic       oled_rst_n, oled_rst_n_b;
`endif

  spi_oled_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_byte(in_byte), .in_dc(in_dc), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_cs_n(spi_cs_n), .spi_dc(spi_dc), .init_done(init_done), .busy(busy)
`ifdef SPI_OLED_RESET_PULSE_EN
    , .oled_rst_n(oled_rst_n)
`endif
  );

  spi_oled_ctrl #(.CLK_DIV(2), .INIT_LEN(0)) dut_b (
    .clk(clk), .rst(rst_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_byte(in_byte_b), .in_dc(in_dc_b), .spi_clk(spi_clk_b), .spi_mosi(spi_mosi_b),
    .spi_cs_n(spi_cs_n_b), .spi_dc(spi_dc_b), .init_done(init_done_b), .busy(busy_b)
`ifdef SPI_OLED_RESET_PULSE_EN
    , .oled_rst_n(oled_rst_n_b)
`endif
  );

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0] b;
    logic       dc;
  } exp_t;

  exp_t sb[$];
  logic [7:0] init_tab [8] = '{8'h8D, 8'h14, 8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hA4, 8'hAF};

  task automatic push_init();
    for (int i = 0; i < 8; i++) sb.push_back({init_tab[i], 1'b0});
  endtask

  // Monitor: assemble bytes at spi_clk rising edges, check against scoreboard.
  logic       prev_sclk = 1'b0;
  int         bitn = 0;
  int         span = 0;
  logic [7:0] rx = 8'h00;
  logic       dc_ok = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      bitn = 0; span = 0; prev_sclk = 1'b0; dc_ok = 1'b1;
    end else begin
      if (!spi_cs_n) begin
        span++;
        if (spi_clk && !prev_sclk) begin
          rx = {rx[6:0], spi_mosi};
          bitn++;
          if (sb.size() > 0 && spi_dc !== sb[0].dc) dc_ok = 1'b0;
          if (bitn == 8) begin
            bitn = 0;
            if (sb.size() == 0) begin
              compared++;
              mismatched++;
              $error("FAIL sb_underflow: observed byte %0h expected none", rx);
            end else begin
              exp_t e;
              e = sb.pop_front();
              chk("mosi_byte", 32'(rx), 32'(e.b));
              chk("dc_stable", 32'(dc_ok), 32'(1));
            end
            dc_ok = 1'b1;
          end
        end
      end else if (span != 0) begin
        chk("cs_low_span", span, 32);
        span = 0;
      end
      prev_sclk = spi_clk;
    end
  end

  initial begin
    int n, m, early, low_b;
    logic first_cs;
    logic [15:0] pat_b;
    logic [7:0]  rx_b;

    rst = 1'b1; in_valid = 1'b0; in_byte = 8'h00; in_dc = 1'b0;
    rst_b = 1'b1; in_valid_b = 1'b0; in_byte_b = 8'h00; in_dc_b = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values.
    chk("rst_cs_n", 32'(spi_cs_n), 32'(1));
    chk("rst_spi_clk", 32'(spi_clk), 32'(0));
    chk("rst_mosi", 32'(spi_mosi), 32'(0));
    chk("rst_dc", 32'(spi_dc), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(0));
    chk("rst_init_done", 32'(init_done), 32'(0));
    chk("rst_busy", 32'(busy), 32'(1));
    chk("rst_b_init_done", 32'(init_done_b), 32'(0));
    chk("rst_b_busy", 32'(busy_b), 32'(1));

    // Host holds A5 (data) throughout init; it must wait for init_done.
    in_valid = 1'b1; in_byte = 8'hA5; in_dc = 1'b1;
    rst = 1'b0; rst_b = 1'b0;
    push_init();
    early = 0; first_cs = 1'b1;
    for (n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (n == 1) begin
        first_cs = spi_cs_n;
        chk("b_init_done_one_cycle", 32'(init_done_b), 32'(1));
        chk("b_ready_one_cycle", 32'(in_ready_b), 32'(1));
      end
      if (in_ready && !init_done) early++;
      if (init_done) break;
    end
    chk("cs_fall_first_cycle", 32'(first_cs), 32'(0));
    chk("init_done_latency", n, 280);
    chk("no_early_ready", early, 0);
    chk("ready_with_init_done", 32'(in_ready), 32'(1));

    // This cycle is the acceptance cycle; the byte is captured on the next edge.
    sb.push_back({8'hA5, 1'b1});
    @(negedge clk);
    chk("ready_low_after_accept", 32'(in_ready), 32'(0));
    chk("busy_after_accept", 32'(busy), 32'(1));
    in_valid = 1'b0;
    m = 1;
    while (!in_ready && m < 200) begin
      @(negedge clk);
      m++;
    end
    chk("ready_return_cycles", m, 35);
    chk("sb_drained_host", sb.size(), 0);

    // Reset in the middle of init byte 3, then check the restart.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    sb.delete();
    rst = 1'b0;
    push_init();
    repeat (80) @(negedge clk);
    chk("mid_byte_cs_low", 32'(spi_cs_n), 32'(0));
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_cs_n", 32'(spi_cs_n), 32'(1));
    chk("midrst_spi_clk", 32'(spi_clk), 32'(0));
    chk("midrst_init_done", 32'(init_done), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(1));
    chk("midrst_mosi", 32'(spi_mosi), 32'(0));
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    push_init();
    for (n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (init_done) break;
    end
    chk("reinit_latency", n, 280);
    chk("sb_drained_reinit", sb.size(), 0);

    // CLK_DIV=2 instance: byte 3C in 16 cycles, spi_clk toggling every cycle.
    chk("b_ready_idle", 32'(in_ready_b), 32'(1));
    in_valid_b = 1'b1; in_byte_b = 8'h3C; in_dc_b = 1'b0;
    @(negedge clk);
    in_valid_b = 1'b0;
    low_b = 0; pat_b = 16'h0000; rx_b = 8'h00;
    for (int k = 0; k < 16; k++) begin
      pat_b[k] = spi_clk_b;
      if (!spi_cs_n_b) low_b++;
      if (spi_clk_b) rx_b = {rx_b[6:0], spi_mosi_b};
      @(negedge clk);
    end
    chk("b_clk_pattern", 32'(pat_b), 32'(16'hAAAA));
    chk("b_cs_low_cycles", low_b, 16);
    chk("b_byte", 32'(rx_b), 32'(8'h3C));
    chk("b_dc", 32'(spi_dc_b), 32'(0));
    chk("b_cs_high_gap", 32'(spi_cs_n_b), 32'(1));
    chk("b_busy_gap", 32'(busy_b), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
